// File: rtl/fp16_normalize_pack.sv
// fp16_normalize_pack: return path of the block-exponent datapath.
// Takes a signed-magnitude sum at a shared block exponent and produces one
// IEEE fp16 result through an iterative normalise, an RNE round and a pack.
// One operation is in flight at a time, with valid/ready on both sides.
module fp16_normalize_pack #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sign,
  input  logic [4:0]   in_exp,
  input  logic [W-1:0] in_mag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic         out_ovf
);

  localparam int unsigned EW   = 7;   // working exponent, wide enough for W-11 right shifts past 31
  localparam int unsigned RW   = 12;  // hidden bit + fraction + carry out of the round increment
  localparam int unsigned EMAX = 31;  // first exponent value that encodes as infinity

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic           r_sign;
  logic [W-1:0]   r_m;
  logic           r_g;
  logic           r_s;
  logic [EW-1:0]  r_e;
  logic           r_out_valid;
  logic [15:0]    r_out_data;
  logic           r_out_ovf;

  state_t         w_state_nxt;
  logic           w_sign_nxt;
  logic [W-1:0]   w_m_nxt;
  logic           w_g_nxt;
  logic           w_s_nxt;
  logic [EW-1:0]  w_e_nxt;
  logic           w_out_valid_nxt;
  logic [15:0]    w_out_data_nxt;
  logic           w_out_ovf_nxt;

  logic           w_inc;
  logic [RW-1:0]  w_r;
  logic [9:0]     w_frac;
  logic [EW-1:0]  w_ef;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  // State and datapath registers; reset drops any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_m         <= '0;
      r_g         <= 1'b0;
      r_s         <= 1'b0;
      r_e         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sign      <= w_sign_nxt;
      r_m         <= w_m_nxt;
      r_g         <= w_g_nxt;
      r_s         <= w_s_nxt;
      r_e         <= w_e_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  // Next-state and datapath: one normalise step per cycle, then round and pack.
  always_comb begin
    w_state_nxt     = r_state;
    w_sign_nxt      = r_sign;
    w_m_nxt         = r_m;
    w_g_nxt         = r_g;
    w_s_nxt         = r_s;
    w_e_nxt         = r_e;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_ovf_nxt   = r_out_ovf;

    // Round-to-nearest-even on the 11-bit significand using guard and sticky.
    w_inc  = r_g & (r_s | r_m[0]);
    w_r    = {1'b0, r_m[10:0]} + RW'(w_inc);
    w_frac = 10'h000;
    w_ef   = '0;

    unique case (r_state)
      S_IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (in_valid) begin
          w_sign_nxt = in_sign;
          w_m_nxt    = in_mag;
          w_g_nxt    = 1'b0;
          w_s_nxt    = 1'b0;
          w_e_nxt    = (in_exp == 5'd0) ? EW'(1) : EW'(in_exp);
          if (in_mag == '0) begin
            // Exact zero always packs as +0.
            w_out_data_nxt = 16'h0000;
            w_out_ovf_nxt  = 1'b0;
            w_state_nxt    = S_DONE;
          end else begin
            w_state_nxt = S_NORM;
          end
        end
      end

      S_NORM: begin
        if (|r_m[W-1:11]) begin
          w_m_nxt = r_m >> 1;
          w_g_nxt = r_m[0];
          w_s_nxt = r_s | r_g;
          w_e_nxt = r_e + EW'(1);
        end else if (!r_m[10] && (r_e > EW'(1))) begin
          w_m_nxt = r_m << 1;
          w_e_nxt = r_e - EW'(1);
        end else begin
          w_state_nxt = S_ROUND;
        end
      end

      S_ROUND: begin
        if (w_r[11]) begin
          w_frac = 10'h000;
          w_ef   = r_e + EW'(1);
        end else begin
          // A subnormal that rounds up to 0x400 lands on exponent field 1 here.
          w_frac = w_r[9:0];
          w_ef   = w_r[10] ? r_e : EW'(0);
        end
        if (w_ef >= EW'(EMAX)) begin
          w_out_data_nxt = {r_sign, 5'h1F, 10'h000};
          w_out_ovf_nxt  = 1'b1;
        end else begin
          w_out_data_nxt = {r_sign, w_ef[4:0], w_frac};
          w_out_ovf_nxt  = 1'b0;
        end
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end

      S_DONE: begin
        // Entry from the zero path arrives with valid still low; raise it here.
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Testbench for fp16_normalize_pack: directed vectors with literal expectations,
// an arithmetic reference model, and a monitor that checks every valid cycle.
module tb_fp16_normalize_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [15:0] in_mag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  fp16_normalize_pack #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic        sg;
    logic [4:0]  ex;
    logic [15:0] mg;
    logic [15:0] d;
    logic        o;
    logic [7:0]  lat;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic mon_prev_v = 1'b0;
  vec_t vecs[14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: value = mag * 2^(E-25); pick the fp16 quantum from the leading one
  // (or the subnormal floor), round-half-even, then encode.
  task automatic model(input logic sg, input logic [4:0] ex, input logic [15:0] mg,
                       output logic [15:0] d, output logic o, output int lat);
    longint m, q, rem, half;
    int     e_blk, p, sh, fld, k;
    m     = longint'(mg);
    e_blk = (ex == 5'd0) ? 1 : int'(ex);
    if (mg == 16'h0000) begin
      d = 16'h0000; o = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 16; i++) if (mg[i]) p = i;
    sh = p - 10;
    if (sh < 1 - e_blk) sh = 1 - e_blk;
    if (sh <= 0) begin
      q = m << (-sh);
    end else begin
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    end
    if (q >= 2048) begin
      q  = q >> 1;
      sh = sh + 1;
    end
    fld = (q >= 1024) ? (sh + e_blk) : 0;
    if (fld >= 31) begin
      d = {sg, 5'h1F, 10'h000}; o = 1'b1;
    end else begin
      d = {sg, 5'(fld), 10'(q)}; o = 1'b0;
    end
    if (p > 10) k = p - 10;
    else        k = ((10 - p) < (e_blk - 1)) ? (10 - p) : (e_blk - 1);
    lat = k + 2;
  endtask

  // Offer one operand, wait for acceptance and queue the model's expectation.
  task automatic send(input logic sg, input logic [4:0] ex, input logic [15:0] mg);
    exp_t e;
    int   n;
    model(sg, ex, mg, e.d, e.o, e.lat);
    exp_q.push_back(e);
    in_sign  = sg;
    in_exp   = ex;
    in_mag   = mg;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      void'(exp_q.pop_back());
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 accept_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compare outputs against the expectation queue on every valid cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_v = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        chk("idle_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        cur = exp_q[0];
        chk("out_data", 32'(out_data), 32'(cur.d));
        chk("out_ovf", 32'(out_ovf), 32'(cur.o));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (!mon_prev_v) chk("latency", 32'(cyc - accept_cyc), 32'(cur.lat));
        if (out_ready) void'(exp_q.pop_front());
      end
      mon_prev_v = out_valid && !out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] md;
    logic        mo;
    int          ml;
    logic [15:0] mg;

    vecs = '{
      '{1'b0, 5'd15, 16'h0400, 16'h3C00, 1'b0, 8'd2},
      '{1'b0, 5'd15, 16'h0C00, 16'h4200, 1'b0, 8'd3},
      '{1'b0, 5'd15, 16'h0100, 16'h3400, 1'b0, 8'd4},
      '{1'b0, 5'd15, 16'h0801, 16'h4000, 1'b0, 8'd3},
      '{1'b0, 5'd15, 16'h0803, 16'h4002, 1'b0, 8'd3},
      '{1'b1, 5'd15, 16'h0400, 16'hBC00, 1'b0, 8'd2},
      '{1'b0, 5'd1,  16'h0200, 16'h0200, 1'b0, 8'd2},
      '{1'b0, 5'd0,  16'h0400, 16'h0400, 1'b0, 8'd2},
      '{1'b1, 5'd15, 16'h0000, 16'h0000, 1'b0, 8'd1},
      '{1'b0, 5'd30, 16'h0FFF, 16'h7C00, 1'b1, 8'd3},
      '{1'b0, 5'd1,  16'h0001, 16'h0001, 1'b0, 8'd2},
      '{1'b0, 5'd31, 16'hFFFF, 16'h7C00, 1'b1, 8'd7},
      '{1'b0, 5'd5,  16'h0001, 16'h0010, 1'b0, 8'd6},
      '{1'b0, 5'd15, 16'h1003, 16'h4401, 1'b0, 8'd4}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 5'd0;
    in_mag    = 16'h0000;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: literal values pin the model, the monitor checks the DUT.
    foreach (vecs[i]) begin
      model(vecs[i].sg, vecs[i].ex, vecs[i].mg, md, mo, ml);
      chk("model_data", 32'(md), 32'(vecs[i].d));
      chk("model_ovf", 32'(mo), 32'(vecs[i].o));
      chk("model_lat", 32'(ml), 32'(vecs[i].lat));
      send(vecs[i].sg, vecs[i].ex, vecs[i].mg);
      wait_done();
    end

    // Spread of magnitudes and exponents checked against the model only.
    for (int i = 0; i < 40; i++) begin
      mg = 16'($urandom) >> $urandom_range(0, 15);
      if (i % 13 == 0) mg = 16'h0000;
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), mg);
      wait_done();
    end

    // Backpressure: result holds and the block stays busy while out_ready is low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(1'b0, 5'd15, 16'h0C00);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_data_hold", 32'(out_data), 32'h4200);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();

    // Reset in the middle of a long left-normalise drops the operation.
    send(1'b0, 5'd20, 16'h0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_data", 32'(out_data), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      chk("postrst_no_valid", 32'(out_valid), 32'd0);
    end
    chk("postrst_in_ready", 32'(in_ready), 32'd1);

    // Normal operation resumes after the reset.
    send(1'b0, 5'd20, 16'h0001);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
